// File: rtl/z80_bus_cycler.sv
// Z80 pin-level machine-cycle generator: runs one accepted bus request as a T-state sequence
// with automatic and external wait states, refresh addressing and zero-gap back-to-back issue.
module z80_bus_cycler #(
    parameter int ADDR_W    = 16,
    parameter int DATA_W    = 8,
    parameter int RFSH_W    = 7,
    parameter int MEM_WAIT  = 0,
    parameter int IO_WAIT   = 1,
    parameter int INTA_WAIT = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [2:0]        req_type,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [ADDR_W-9:0] i_reg,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic [ADDR_W-1:0] A,
    input  logic [DATA_W-1:0] D_in,
    output logic [DATA_W-1:0] D_out,
    output logic              D_oe,
    output logic              nM1,
    output logic              nMREQ,
    output logic              nIORQ,
    output logic              nRD,
    output logic              nWR,
    output logic              nRFSH,
    input  logic              nWAIT
);
    typedef enum logic [2:0] {S_IDLE, S_T1, S_T2, S_TW, S_T3, S_T4} state_t;

    state_t            r_state, w_nstate;
    logic [2:0]        r_type;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [7:0]        r_wcnt;
    logic [RFSH_W-1:0] r_rfsh;
    logic              r_rsp;
    logic [DATA_W-1:0] r_rdata;
    logic [5:0]        r_strb, w_strb;   // {nM1, nMREQ, nIORQ, nRD, nWR, nRFSH}
    logic [ADDR_W-1:0] r_a, w_a;
    logic [DATA_W-1:0] r_dout, w_dout;
    logic              r_doe, w_doe;

    logic              w_fi, w_nfi, w_null, w_ready, w_acc, w_t1;
    logic [2:0]        w_ntype;
    logic [ADDR_W-1:0] w_naddr;
    logic [DATA_W-1:0] w_nwdata;
    logic [7:0]        w_rf8;

    function automatic logic [7:0] wait_of(input logic [2:0] t);
        case (t)
            3'd0, 3'd1, 3'd2: return 8'(MEM_WAIT);
            3'd3, 3'd4:       return 8'(IO_WAIT);
            3'd5:             return 8'(INTA_WAIT);
            default:          return 8'd0;
        endcase
    endfunction

    assign w_fi   = (r_type == 3'd0) || (r_type == 3'd5);
    assign w_null = req_type[2] & req_type[1];
    // A null accepted in a non-fetch T3 would collide with that cycle's response pulse.
    assign w_ready = (r_state == S_IDLE) || (r_state == S_T4) ||
                     ((r_state == S_T3) && !w_fi && !w_null);
    assign req_ready = !reset && w_ready;
    assign w_acc     = req_valid && req_ready;

    assign w_ntype  = w_acc ? req_type  : r_type;
    assign w_naddr  = w_acc ? req_addr  : r_addr;
    assign w_nwdata = w_acc ? req_wdata : r_wdata;
    assign w_nfi    = (w_ntype == 3'd0) || (w_ntype == 3'd5);
    assign w_rf8    = 8'(r_rfsh);
    assign w_t1     = (w_nstate == S_T1);

    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_nstate;
    end

    always_comb begin
        w_nstate = r_state;
        case (r_state)
            S_T1:       w_nstate = S_T2;
            S_T2, S_TW: w_nstate = (|r_wcnt || !nWAIT) ? S_TW : S_T3;
            default: begin
                if (w_acc)                       w_nstate = w_null ? S_IDLE : S_T1;
                else if (r_state == S_T3 && w_fi) w_nstate = S_T4;
                else                             w_nstate = S_IDLE;
            end
        endcase
    end

    // Pin values for the upcoming T-state; registered below so strobes never glitch.
    always_comb begin
        w_strb = 6'h3F;
        w_a    = r_a;
        w_dout = r_dout;
        w_doe  = 1'b0;
        if ((w_nstate == S_T3 || w_nstate == S_T4) && w_nfi) begin
            w_strb = 6'b101110;
            w_a    = {i_reg, w_rf8};
        end else if (w_nstate != S_IDLE) begin
            w_a = w_naddr;
            case (w_ntype)
                3'd0: w_strb = 6'b001011;
                3'd1: w_strb = 6'b101011;
                3'd2: begin
                    w_strb = {4'b1011, w_t1, 1'b1};
                    w_doe  = 1'b1;
                    w_dout = w_nwdata;
                end
                3'd3: w_strb = {2'b11, w_t1, w_t1, 2'b11};
                3'd4: begin
                    w_strb = {2'b11, w_t1, 1'b1, w_t1, 1'b1};
                    w_doe  = 1'b1;
                    w_dout = w_nwdata;
                end
                3'd5: w_strb = {2'b01, (w_nstate != S_TW), 3'b111};
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_type  <= '0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_wcnt  <= '0;
            r_rfsh  <= '0;
            r_rsp   <= 1'b0;
            r_rdata <= '0;
            r_strb  <= 6'h3F;
            r_a     <= '0;
            r_dout  <= '0;
            r_doe   <= 1'b0;
        end else begin
            r_strb <= w_strb;
            r_a    <= w_a;
            r_dout <= w_dout;
            r_doe  <= w_doe;
            r_rsp  <= 1'b0;
            if (w_acc) begin
                r_type  <= req_type;
                r_addr  <= req_addr;
                r_wdata <= req_wdata;
            end
            if (r_state == S_T1)
                r_wcnt <= wait_of(r_type);
            else if (w_nstate == S_TW && |r_wcnt)
                r_wcnt <= r_wcnt - 8'd1;
            if (r_state == S_T4)
                r_rfsh <= r_rfsh + 1'b1;
            if (w_fi && (r_state == S_T2 || r_state == S_TW) && w_nstate == S_T3) begin
                r_rdata <= D_in;
                r_rsp   <= 1'b1;
            end
            if (r_state == S_T3 && !w_fi) begin
                r_rsp <= 1'b1;
                if (r_type == 3'd1 || r_type == 3'd3) r_rdata <= D_in;
            end
            if (w_acc && w_null) begin
                r_rsp   <= 1'b1;
                r_rdata <= '1;
            end
        end
    end

    assign {nM1, nMREQ, nIORQ, nRD, nWR, nRFSH} = r_strb;
    assign A         = r_a;
    assign D_out     = r_dout;
    assign D_oe      = r_doe;
    assign rsp_valid = r_rsp;
    assign rsp_rdata = r_rdata;
endmodule

// File: tb/tb_z80_bus_cycler.sv
// Directed plus randomized check of z80_bus_cycler against a phase-list model:
// wait count, strobes, address, data enable and response timing per request.
module tb_z80_bus_cycler;
    localparam int MEM_W = 0, IO_W = 1, INTA_W = 2;
    localparam int P_T1 = 1, P_T2 = 2, P_TW = 3, P_T3 = 4, P_T4 = 5;

    logic        clk, reset, req_valid, req_ready, rsp_valid, D_oe, nWAIT;
    logic        nM1, nMREQ, nIORQ, nRD, nWR, nRFSH;
    logic [2:0]  req_type;
    logic [15:0] req_addr, A;
    logic [7:0]  req_wdata, i_reg, rsp_rdata, D_in, D_out;
    logic [5:0]  strb;

    int          total, bad, nwr_cnt;
    logic [6:0]  r_model;
    logic [7:0]  prev_rdata;
    logic [5:0]  bb_strb [7];
    logic        bb_doe  [7];
    logic        bb_rsp  [7];
    logic        bb_rdy  [7];

    assign strb = {nM1, nMREQ, nIORQ, nRD, nWR, nRFSH};

    z80_bus_cycler #(
        .ADDR_W(16), .DATA_W(8), .RFSH_W(7),
        .MEM_WAIT(MEM_W), .IO_WAIT(IO_W), .INTA_WAIT(INTA_W)
    ) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_type(req_type),
        .req_addr(req_addr), .req_wdata(req_wdata), .i_reg(i_reg),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .A(A), .D_in(D_in), .D_out(D_out), .D_oe(D_oe),
        .nM1(nM1), .nMREQ(nMREQ), .nIORQ(nIORQ), .nRD(nRD), .nWR(nWR), .nRFSH(nRFSH),
        .nWAIT(nWAIT)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Strobe vector {nM1,nMREQ,nIORQ,nRD,nWR,nRFSH} for a cycle type in a given T-state.
    function automatic logic [5:0] exp_str(input int ty, input int ph);
        logic m1, mq, io, rd, wr, rf;
        m1 = 1; mq = 1; io = 1; rd = 1; wr = 1; rf = 1;
        if ((ty == 0 || ty == 5) && ph >= P_T3) begin
            mq = 0; rf = 0;
        end else begin
            case (ty)
                0: begin m1 = 0; mq = 0; rd = 0; end
                1: begin mq = 0; rd = 0; end
                2: begin mq = 0; wr = (ph == P_T1); end
                3: begin io = (ph == P_T1); rd = (ph == P_T1); end
                4: begin io = (ph == P_T1); wr = (ph == P_T1); end
                5: begin m1 = 0; io = (ph != P_TW); end
                default: ;
            endcase
        end
        return {m1, mq, io, rd, wr, rf};
    endfunction

    // Issue one request from idle; nw[j] is nWAIT at the j-th wait decision point.
    task automatic run(input int ty, input logic [15:0] ad, input logic [7:0] wd,
                       input logic [7:0] din, input logic [15:0] nw);
        bit fi;
        int w, k, n, ph, cap;
        logic [15:0] ea, rfa;
        fi  = (ty == 0 || ty == 5);
        w   = (ty == 5) ? INTA_W : (ty == 3 || ty == 4) ? IO_W : (ty <= 2) ? MEM_W : 0;
        k   = 0;
        while (k < 15 && (k < w || nw[k] == 1'b0)) k++;
        n   = 3 + k + (fi ? 1 : 0);
        cap = fi ? 1 + k : 2 + k;
        rfa = {i_reg, 1'b0, r_model};
        req_valid = 1; req_type = 3'(ty); req_addr = ad; req_wdata = wd;
        nWAIT = 1'($urandom); D_in = 8'($urandom);
        chk("ready_acc", req_ready, 1);
        if (ty >= 6) begin
            @(negedge clk);
            req_valid = 0;
            chk("null_rsp", rsp_valid, 1);
            chk("null_rdata", rsp_rdata, 8'hFF);
            chk("null_strb", strb, 6'h3F);
            chk("null_doe", D_oe, 0);
            prev_rdata = 8'hFF;
            return;
        end
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            req_valid = 0; req_type = 0;
            ph = (i == 0) ? P_T1 : (i == 1) ? P_T2 : (i <= 1 + k) ? P_TW :
                 (i == 2 + k) ? P_T3 : P_T4;
            ea = (fi && ph >= P_T3) ? rfa : ad;
            chk("strb", strb, exp_str(ty, ph));
            chk("addr", A, ea);
            chk("doe", D_oe, (ty == 2 || ty == 4));
            if (ty == 2 || ty == 4) chk("dout", D_out, wd);
            chk("rsp", rsp_valid, fi && ph == P_T3);
            if (fi && ph == P_T3) chk("fetch_rdata", rsp_rdata, din);
            chk("ready", req_ready, (fi && ph == P_T4) || (!fi && ph == P_T3));
            nWAIT = (ph == P_T2 || ph == P_TW) ? nw[i - 1] : 1'($urandom);
            D_in  = (i == cap) ? din : 8'($urandom);
        end
        @(negedge clk);
        chk("idle_strb", strb, 6'h3F);
        chk("idle_doe", D_oe, 0);
        chk("idle_addr", A, fi ? rfa : ad);
        chk("idle_rsp", rsp_valid, !fi);
        chk("idle_ready", req_ready, 1);
        if (!(ty == 2 || ty == 4)) prev_rdata = din;
        chk("idle_rdata", rsp_rdata, prev_rdata);
        if (fi) r_model++;
    endtask

    initial begin
        total = 0; bad = 0; r_model = 0; prev_rdata = 0;
        reset = 1; req_valid = 0; req_type = 0; req_addr = 0; req_wdata = 0;
        i_reg = 8'h5A; D_in = 0; nWAIT = 1;
        repeat (2) @(negedge clk);
        chk("rst_strb", strb, 6'h3F);
        chk("rst_addr", A, 0);
        chk("rst_dout", D_out, 0);
        chk("rst_doe", D_oe, 0);
        chk("rst_rsp", rsp_valid, 0);
        chk("rst_rdata", rsp_rdata, 0);
        chk("rst_ready", req_ready, 0);
        reset = 0;
        @(negedge clk);
        chk("ready_after_rst", req_ready, 1);

        run(0, 16'h1234, 8'h00, 8'h3E, 16'hFFFF);
        run(3, 16'h00FE, 8'h00, 8'hC3, 16'hFFF9);
        run(5, 16'h0038, 8'h00, 8'hFF, 16'hFFFF);

        // Write then read, both held valid: read T1 immediately follows write T3.
        bb_strb = '{6'b101111, 6'b101101, 6'b101101, 6'b101011, 6'b101011, 6'b101011, 6'b111111};
        bb_doe  = '{1, 1, 1, 0, 0, 0, 0};
        bb_rsp  = '{0, 0, 0, 1, 0, 0, 1};
        bb_rdy  = '{0, 0, 1, 0, 0, 1, 1};
        req_valid = 1; req_type = 2; req_addr = 16'h8000; req_wdata = 8'hA5; nWAIT = 1; D_in = 0;
        chk("bb_ready", req_ready, 1);
        nwr_cnt = 0;
        for (int c = 0; c < 7; c++) begin
            @(negedge clk);
            if (c == 0) begin req_type = 1; req_wdata = 0; end
            if (c == 3) req_valid = 0;
            chk("bb_strb", strb, bb_strb[c]);
            chk("bb_doe", D_oe, bb_doe[c]);
            chk("bb_rsp", rsp_valid, bb_rsp[c]);
            chk("bb_ready", req_ready, bb_rdy[c]);
            chk("bb_addr", A, 16'h8000);
            if (bb_doe[c]) chk("bb_dout", D_out, 8'hA5);
            if (c == 3) chk("bb_wr_rdata", rsp_rdata, prev_rdata);
            if (c == 6) chk("bb_rd_rdata", rsp_rdata, 8'h5C);
            if (!nWR) nwr_cnt++;
            D_in = (c == 5) ? 8'h5C : 8'h00;
        end
        chk("bb_nwr_cycles", nwr_cnt, 2);
        prev_rdata = 8'h5C;
        req_type = 0;

        for (int f = 0; f < 130; f++) run(0, 16'($urandom), 8'h00, 8'($urandom), 16'hFFFF);

        for (int t = 0; t < 60; t++) begin
            i_reg = 8'($urandom);
            run(int'($urandom_range(0, 7)), 16'($urandom), 8'($urandom), 8'($urandom),
                16'($urandom | $urandom) | 16'hFF00);
        end

        // Reset during TW of an IO write aborts it and clears the refresh counter.
        req_valid = 1; req_type = 4; req_addr = 16'h0042; req_wdata = 8'h77; nWAIT = 0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            req_valid = 0;
        end
        chk("mid_tw_strb", strb, 6'b110101);
        reset = 1;
        @(negedge clk);
        chk("mid_rst_strb", strb, 6'h3F);
        chk("mid_rst_doe", D_oe, 0);
        chk("mid_rst_rsp", rsp_valid, 0);
        chk("mid_rst_ready", req_ready, 0);
        chk("mid_rst_addr", A, 0);
        reset = 0; nWAIT = 1; req_type = 0;
        @(negedge clk);
        chk("post_rst_rsp", rsp_valid, 0);
        chk("post_rst_ready", req_ready, 1);
        chk("post_rst_rdata", rsp_rdata, 0);
        r_model = 0; prev_rdata = 0;
        run(0, 16'h4321, 8'h00, 8'h99, 16'hFFFF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/z80_bus_cycler.md
Name: z80_bus_cycler

Overview:
- Parametrised pin-level machine-cycle generator for the Z80 core.
- Accepts one bus request at a time from the sequencer side and runs it as a T-state sequence on the external control, address and data pins: opcode fetch with refresh, memory read/write, IO read/write, or interrupt acknowledge.
- Generalises the fixed 8/16-bit pin logic to configurable address, data and refresh widths.
- Adds per-cycle-type automatic wait states on top of nWAIT, a registered refresh counter, and back-to-back cycle issue with no idle gap.

Parameters:
- ADDR_W, 16: address bus width; must be ≥ 9.
- DATA_W, 8: data bus width.
- RFSH_W, 7: refresh counter width, 1..8.
- MEM_WAIT, 0: automatic TW states for memory and fetch cycles.
- IO_WAIT, 1: automatic TW states for IO cycles.
- INTA_WAIT, 2: automatic TW states for interrupt acknowledge.

Ports:
- clk  in  1  system clock; one T-state per clk cycle.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted when valid && ready.
- req_type  in  3  0 fetch, 1 mem rd, 2 mem wr, 3 io rd, 4 io wr, 5 int ack, 6–7 null.
- req_addr  in  ADDR_W  cycle address.
- req_wdata  in  DATA_W  write data.
- i_reg  in  ADDR_W-8  refresh address upper bits.
- rsp_valid  out  1  one-cycle pulse: read data valid / cycle done.
- rsp_rdata  out  DATA_W  captured read data.
- A  out  ADDR_W  address pins.
- D_in  in  DATA_W  data pins, input side.
- D_out  out  DATA_W  data pins, output side.
- D_oe  out  1  data pin output enable.
- nM1, nMREQ, nIORQ, nRD, nWR, nRFSH  out  1 each  active-low strobes.
- nWAIT  in  1  active-low wait, sampled on clk.

Behaviour:
- **Reset values** (in the cycle after reset is sampled high):
  - All strobes = 1; A = 0; D_out = 0; D_oe = 0.
  - rsp_valid = 0; rsp_rdata = 0; refresh counter r = 0.
  - State = IDLE.
  - req_ready = 0 while reset is high.
  - Reset mid-cycle aborts the cycle; no rsp_valid is produced for it.
- **States:** IDLE, T1, T2, TW, T3, T4. A request is latched into cycle registers on acceptance.
- **req_ready:** high in IDLE, in T3 of non-fetch/non-inta cycles, and in T4 of fetch/inta cycles. An accept in that last T-state enters T1 on the next clk (zero-gap back-to-back issue).
- **Wait logic:**
  - An automatic-wait counter is loaded at T1 with the cycle-type wait parameter.
  - At the end of T2 and of each TW, the next state is TW if counter > 0 or nWAIT = 0; otherwise T3.
  - The counter decrements in each TW and saturates at 0.
  - nWAIT is ignored in T1, T3 and T4.
- **Fetch (type 0):**
  - T1–T2–TW*: A = addr; nM1 = nMREQ = nRD = 0.
  - D_in is captured at the end of the last T2/TW.
  - T3–T4: nM1 = nRD = 1; nRFSH = nMREQ = 0; A = {i_reg, zero-extended r}.
  - rsp_valid pulses in T3.
  - r increments, wrapping modulo 2^RFSH_W, at the end of T4.
- **Memory read (type 1):**
  - T1–T3: nMREQ = nRD = 0; A = addr.
  - D_in is captured at the end of T3; rsp_valid pulses the next cycle.
- **Memory write (type 2):**
  - T1–T3: nMREQ = 0; D_oe = 1; D_out = wdata.
  - nWR = 0 in T2, TW and T3.
  - rsp_valid pulses the cycle after T3 with rsp_rdata unchanged.
- **IO read/write (types 3, 4):**
  - T1: nIORQ = 1.
  - T2, TW, T3: nIORQ = 0 with nRD (or nWR) = 0.
  - Write data is driven as for memory write; read capture and rsp_valid timing as for memory read.
- **Interrupt acknowledge (type 5):**
  - Same as fetch, except nMREQ and nRD stay 1 in T1–TW.
  - nIORQ = 0 in every TW and stays 1 elsewhere.
  - Data is captured at the end of the last TW; refresh in T3–T4 as for fetch.
- **Null types (6, 7):** accepted; no pin activity; rsp_valid pulses the next cycle with rsp_rdata = all ones.
- **Pins outside cycles:** strobes = 1; A holds its last value; D_oe = 0.
- **Strobe glitches:** no strobe may glitch between back-to-back cycles; each strobe is a registered output.

Test Plan:
- **Fetch, no wait:** after reset, fetch at 0x1234, D_in = 0x3E, i_reg = 0x5A.
  - Expect 4 cycles T1..T4; nM1 low for 2 cycles; rsp_rdata = 0x3E in T3.
  - A = 0x5A00 in T3/T4; then r = 1.
- **IO read with nWAIT:** IO read at 0x00FE with nWAIT low for 2 sampled cycles.
  - Expect T1 T2 TW TW TW T3 (1 auto + 2 external waits); nIORQ low for 5 cycles.
  - Data captured at end of T3; rsp_valid one cycle later.
- **Back-to-back:** mem wr 0x8000 ← 0xA5, then mem rd 0x8000, both held valid.
  - Expect T1 of the read in the cycle right after the write's T3.
  - nWR = 0 for exactly 2 cycles; D_oe drops with the write's T3.
- **Refresh wrap:** 128 fetches with RFSH_W = 7.
  - Expect refresh A[7:0] to step 0x00..0x7F, then 0x00 again; bit 7 always 0.
- **Reset mid-cycle:** assert reset during TW of an IO write.
  - Expect all strobes = 1 and D_oe = 0 the next cycle; no rsp_valid; r = 0.
- **Int ack:** type 5, D_in = 0xFF.
  - Expect T1 T2 TW TW T3 T4; nIORQ low only in the two TW cycles; nMREQ low only in T3–T4.
  - rsp_rdata = 0xFF.
